// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the elastic pipeline register
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - WIDTH-bit enable register, synchronous clear to 0
module pipe_data_reg #(
  parameter int WIDTH = 219
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - one-stage elastic register with skid buffer, flush and occupancy
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 219
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      state;
  skid_state_e      state_next;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // in_ready is built from registered state and flush only, never out_ready.
  always_comb begin
    in_ready   = (state != FULL) && !flush;
    out_valid  = (state != EMPTY);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    state_next = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    main_d     = in_data;
    count      = 2'd0;

    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_en    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        count = 2'd1;
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en    = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        count = 2'd2;
        if (out_fire) begin
          main_en    = 1'b1;
          main_d     = skid_q;
          state_next = BUSY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // Flush drops the valid bits only; the data registers keep their contents.
    if (flush) begin
      state_next = EMPTY;
      main_en    = 1'b0;
      skid_en    = 1'b0;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and random checks of pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

  localparam int W = 219;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int tests;
  int failed;
  logic [W-1:0] mq[$];

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, then compare outputs with the queue model.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("in_ready", W'(in_ready), W'((mq.size() < 2) && !fl));
    check("out_valid", W'(out_valid), W'(mq.size() > 0));
    check("count", W'(count), W'(mq.size()));
    if (mq.size() > 0) check("out_data", out_data, mq[0]);
  endtask

  task automatic tick();
    logic m_in_fire;
    logic m_out_fire;
    m_in_fire  = in_valid && (mq.size() < 2) && !flush;
    m_out_fire = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (m_out_fire) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (m_in_fire) mq.push_back(in_data);
    #1;
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    drive(iv, d, ordy, fl);
    tick();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    mq.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    tests    = 0;
    failed   = 0;
    in_data  = '0;
    do_reset();

    // reset state
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_data", out_data, '0);

    // streaming with out_ready held high
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0);
      check("stream_data", out_data, W'(i));
      check("stream_count", W'(count), W'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // backpressure: third beat must stay upstream
    step(1'b1, W'(8'hA1), 1'b0, 1'b0);
    step(1'b1, W'(8'hA2), 1'b0, 1'b0);
    drive(1'b1, W'(8'hA3), 1'b0, 1'b0);
    check("bp_count", W'(count), W'(2));
    check("bp_in_ready", W'(in_ready), W'(0));
    tick();
    drive(1'b1, W'(8'hA3), 1'b1, 1'b0);
    check("bp_head0", out_data, W'(8'hA1));
    tick();
    drive(1'b1, W'(8'hA3), 1'b1, 1'b0);
    check("bp_head1", out_data, W'(8'hA2));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("bp_head2", out_data, W'(8'hA3));
    tick();

    // simultaneous accept and emit in BUSY
    step(1'b1, W'(8'h10), 1'b0, 1'b0);
    step(1'b1, W'(8'h11), 1'b1, 1'b0);
    check("sim_count", W'(count), W'(1));
    check("sim_data", out_data, W'(8'h11));
    step(1'b0, '0, 1'b1, 1'b0);

    // flush while FULL
    step(1'b1, W'(8'h20), 1'b0, 1'b0);
    step(1'b1, W'(8'h21), 1'b0, 1'b0);
    drive(1'b1, W'(8'h22), 1'b0, 1'b1);
    check("fl_in_ready", W'(in_ready), W'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("fl_count", W'(count), W'(0));
    check("fl_out_valid", W'(out_valid), W'(0));
    check("fl_in_ready_after", W'(in_ready), W'(1));

    // reset while FULL
    step(1'b1, W'(8'h30), 1'b0, 1'b0);
    step(1'b1, W'(8'h31), 1'b0, 1'b0);
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("mr_out_valid", W'(out_valid), W'(0));
    check("mr_out_data", out_data, '0);
    check("mr_count", W'(count), W'(0));
    tick();
    step(1'b0, '0, 1'b1, 1'b0);
    check("mr_no_stale", W'(out_valid), W'(0));

    // random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < W; k += 32) rd[k +: 32] = (k + 32 <= W) ? $urandom : W'($urandom) ;
      step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
